// File: rtl/word_decryptor_if.sv
// Job-control and RAM-port bundle for word_decryptor.
// The slave side is the decryptor; the master side issues jobs and serves the RAM.
interface word_decryptor_if;
    logic        start;
    logic [1:0]  op;
    logic [63:0] key;
    logic [5:0]  shamt;
    logic [15:0] base_addr;
    logic [6:0]  len;
    logic [63:0] mem_rdata;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_wren;
    logic        busy;
    logic        done;
    logic        err;
    logic [6:0]  word_cnt;

    modport master (
        output start, op, key, shamt, base_addr, len, mem_rdata,
        input  mem_addr, mem_wdata, mem_wren, busy, done, err, word_cnt
    );

    modport slave (
        input  start, op, key, shamt, base_addr, len, mem_rdata,
        output mem_addr, mem_wdata, mem_wren, busy, done, err, word_cnt
    );
endinterface

// File: rtl/word_decryptor.sv
// In-place decryptor: reads, transforms and rewrites len consecutive 64-bit RAM words,
// four cycles per word (RD, WAIT, CAP, WR), with a one-cycle done pulse at the end.
module word_decryptor (
    input  logic            clk,
    input  logic            rst_n,
    word_decryptor_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, WAIT, CAP, WR, DONE} state_t;

    state_t      r_state;
    logic [1:0]  r_op;
    logic [63:0] r_key;
    logic [5:0]  r_shamt;
    logic [15:0] r_base;
    logic [6:0]  r_len;
    logic [6:0]  r_word_cnt;
    logic [15:0] r_mem_addr;
    logic [63:0] r_mem_wdata;
    logic        r_mem_wren;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic [63:0] w_xform;
    logic [6:0]  w_next_idx;

    always_comb begin
        w_xform = bus.mem_rdata;
        case (r_op)
            2'd0:    w_xform = bus.mem_rdata ^ r_key;
            2'd1:    w_xform = (bus.mem_rdata >> r_shamt) |
                               (bus.mem_rdata << (7'd64 - {1'b0, r_shamt}));
            2'd2:    w_xform = {bus.mem_rdata[31:0], bus.mem_rdata[63:32]};
            default: w_xform = bus.mem_rdata;
        endcase
    end

    // Words written so far always equals the index of the word in flight.
    assign w_next_idx = r_word_cnt + 7'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_key       <= '0;
            r_shamt     <= '0;
            r_base      <= '0;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wren  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_op       <= bus.op;
                        r_key      <= bus.key;
                        r_shamt    <= bus.shamt;
                        r_base     <= bus.base_addr;
                        r_len      <= bus.len;
                        r_word_cnt <= '0;
                        r_err      <= (bus.op == 2'd3);
                        if (bus.len == 7'd0 || bus.op == 2'd3) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= RD;
                            r_busy     <= 1'b1;
                            r_mem_addr <= bus.base_addr;
                        end
                    end
                end
                RD:   r_state <= WAIT;
                WAIT: r_state <= CAP;
                CAP: begin
                    r_state     <= WR;
                    r_mem_wdata <= w_xform;
                    r_mem_wren  <= 1'b1;
                end
                WR: begin
                    r_mem_wren  <= 1'b0;
                    r_mem_wdata <= '0;
                    r_word_cnt  <= w_next_idx;
                    if (w_next_idx == r_len) begin
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_mem_addr <= '0;
                    end else begin
                        r_state    <= RD;
                        r_mem_addr <= r_base + {9'd0, w_next_idx};
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_mem_wren <= 1'b0;
                    r_mem_addr <= '0;
                end
            endcase
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wren  = r_mem_wren;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.word_cnt  = r_word_cnt;
endmodule

// File: doc/word_decryptor.md
WORD_DECRYPTOR -- requirements
Module: word_decryptor

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 Port clk input 1: rising-edge clock for all state.
REQ-003 Port rst_n input 1: synchronous active-low reset, sampled on the clk rising edge.
REQ-004 Port start input 1: request a job; accepted only in IDLE.
REQ-005 Port op input 2: 0 = un-XOR, 1 = rotate-right, 2 = half-swap, 3 = illegal.
REQ-006 Port key input 64: XOR key for op 0.
REQ-007 Port shamt input 6: rotate amount for op 1.
REQ-008 Port base_addr input 16: first RAM word address.
REQ-009 Port len input 7: number of 64-bit words, 0..127.
REQ-010 Port mem_rdata input 64: RAM read data, valid one cycle after mem_addr is presented.
REQ-011 Port mem_addr output 16: RAM address.
REQ-012 Port mem_wdata output 64: RAM write data.
REQ-013 Port mem_wren output 1: RAM write enable.
REQ-014 Port busy output 1: a job is in progress.
REQ-015 Port done output 1: one-cycle job-complete pulse.
REQ-016 Port err output 1: sticky illegal-op flag.
REQ-017 Port word_cnt output 7: words written in the current or last job.

Function
REQ-018 The block SHALL in place decrypt len consecutive 64-bit RAM words starting at base_addr, the inverse of the encrypt side.
REQ-019 The block SHALL use FSM states IDLE, RD, WAIT, CAP, WR and DONE.
REQ-020 In IDLE with start=1, the block SHALL latch op, key, shamt, base_addr and len at that edge, clear word_cnt and err, and set index=0.
REQ-021 After accepting start, the block SHALL go to DONE if len=0 or op=3, otherwise to RD.
REQ-022 In RD, mem_addr SHALL be base_addr+index, wrapping modulo 2^16.
REQ-023 In WAIT, mem_addr SHALL be held and mem_rdata becomes valid.
REQ-024 In CAP, the block SHALL register the transform of mem_rdata.
REQ-025 In WR, the block SHALL drive mem_wren=1, the same mem_addr, and mem_wdata equal to the registered result.
REQ-026 After WR, the block SHALL increment word_cnt, return to RD with index+1 if more words remain, and otherwise go to DONE.
REQ-027 Each word SHALL take exactly 4 cycles; with start accepted at edge 0, the last WR SHALL occur in cycle 4*len and done=1 in cycle 4*len+1.
REQ-028 Transforms SHALL be: op 0 = data XOR key; op 1 = 64-bit rotate right by shamt (shamt=0 gives identity); op 2 = swap the [63:32] and [31:0] halves.
REQ-029 busy SHALL be 1 in RD, WAIT, CAP and WR, and 0 in IDLE and DONE.
REQ-030 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-031 A new start SHALL be accepted no earlier than the cycle after done.
REQ-032 start while busy or in DONE SHALL be ignored, with no effect on latched parameters.
REQ-033 op=3 SHALL set err=1 in the DONE cycle with no RAM write; err SHALL stay set until the next accepted start.
REQ-034 mem_wren SHALL be 0 in every state except WR.
REQ-035 mem_addr and mem_wdata SHALL be 0 in IDLE and DONE.

Reset
REQ-036 rst_n=0 at a rising edge SHALL force IDLE and set busy, done, err, mem_wren, mem_addr, mem_wdata, word_cnt and index to 0 from the next cycle.
REQ-037 Reset mid-job SHALL abort without completing a pending write; words already written stay written, and no done pulse is produced.
REQ-038 rst_n SHALL take priority over start in the same cycle.

Verification
REQ-039 The bench SHALL cover op 0 with mem[0x0010]=0x0123456789ABCDEF, key=0xFFFFFFFF00000000, len=1 -> mem[0x0010]=0xFEDCBA9889ABCDEF, done in cycle 5, word_cnt=1.
REQ-040 The bench SHALL cover op 1 with shamt=8, word 0x0123456789ABCDEF -> 0xEF0123456789ABCD; shamt=0 -> word unchanged and still written.
REQ-041 The bench SHALL cover op 2 with base_addr=0xFFFE, len=3, all words 0x0123456789ABCDEF -> addresses 0xFFFE, 0xFFFF, 0x0000 hold 0x89ABCDEF01234567, done in cycle 13.
REQ-042 The bench SHALL cover len=0 -> done in cycle 1, no mem_wren; op=3, len=5 -> done in cycle 1, err=1, no mem_wren; err cleared by the next accepted start.
REQ-043 The bench SHALL cover rst_n=0 in cycle 6 of a len=4 op 0 job -> busy=0 from cycle 7, only base_addr rewritten, base_addr+1..+3 unchanged, no done pulse.
REQ-044 The bench SHALL cover start pulsed in cycle 3 of a len=2 job with different op/key -> ignored; result matches the original parameters and done occurs in cycle 9.
